// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, fixed CLKS_PER_BIT; one-cycle done/frame_err strobes.
// Optional UART_RX_MAJORITY_EN: each bit sample is the 2-of-3 vote of the last three synchronized values.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic       i_enable,
    output logic [7:0] o_data_out,
    output logic       o_done,
    output logic       o_frame_err
);

    localparam int          HALF    = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_sync1;
    logic        r_rxS;
    logic [15:0] r_cnt;
    logic [15:0] w_cntNext;
    logic [2:0]  r_bitIdx;
    logic [2:0]  w_bitIdxNext;
    logic [7:0]  r_shift;
    logic [7:0]  w_shiftNext;
    logic [7:0]  r_data;
    logic [7:0]  w_dataNext;
    logic        r_done;
    logic        w_doneNext;
    logic        r_frameErr;
    logic        w_frameErrNext;
    logic        w_sample;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sync1 <= 1'b1;
            r_rxS   <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rxS   <= r_sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // r_hist[0] always equals r_rxS; the vote spans it and the two cycles before.
    logic [2:0] r_hist;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_hist <= 3'b111;
        end else begin
            r_hist <= {r_hist[1:0], r_sync1};
        end
    end

    assign w_sample = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
`else
    assign w_sample = r_rxS;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_bitIdxNext   = r_bitIdx;
        w_shiftNext    = r_shift;
        w_dataNext     = r_data;
        w_doneNext     = 1'b0;
        w_frameErrNext = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_enable && !r_rxS) begin
                    w_stateNext = START;
                    w_cntNext   = 16'd0;
                end
            end
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cntNext = 16'd0;
                    if (!w_sample) begin
                        w_stateNext  = DATA;
                        w_bitIdxNext = 3'd0;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else begin
                    w_cntNext = r_cnt + 16'd1;
                end
            end
            DATA: begin
                if (r_cnt == BIT_M1) begin
                    w_cntNext             = 16'd0;
                    w_shiftNext[r_bitIdx] = w_sample;
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_cntNext = r_cnt + 16'd1;
                end
            end
            STOP: begin
                if (r_cnt == BIT_M1) begin
                    w_cntNext   = 16'd0;
                    w_stateNext = IDLE;
                    if (w_sample) begin
                        w_dataNext = r_shift;
                        w_doneNext = 1'b1;
                    end else begin
                        w_frameErrNext = 1'b1;
                    end
                end else begin
                    w_cntNext = r_cnt + 16'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = 16'd0;
            end
        endcase

        // Dropping enable mid-frame throws the frame away silently.
        if (r_state != IDLE && !i_enable) begin
            w_stateNext    = IDLE;
            w_cntNext      = 16'd0;
            w_shiftNext    = 8'h00;
            w_dataNext     = r_data;
            w_doneNext     = 1'b0;
            w_frameErrNext = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt      <= 16'd0;
            r_bitIdx   <= 3'd0;
            r_shift    <= 8'h00;
            r_data     <= 8'h00;
            r_done     <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_cnt      <= w_cntNext;
            r_bitIdx   <= w_bitIdxNext;
            r_shift    <= w_shiftNext;
            r_data     <= w_dataNext;
            r_done     <= w_doneNext;
            r_frameErr <= w_frameErrNext;
        end
    end

    assign o_data_out  = r_data;
    assign o_done      = r_done;
    assign o_frame_err = r_frameErr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (CLKS_PER_BIT=16): frame-timing model predicts every strobe cycle and data_out.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 8192;

    logic       clk = 1'b0;
    logic       rstN;
    logic       rxDrv;
    logic       enDrv;
    logic [7:0] dataOut;
    logic       done;
    logic       frameErr;

    int         edgeCnt = 0;
    int         checks = 0;
    int         failures = 0;
    int         doneCount = 0;
    int         ferrCount = 0;
    int         lastDoneCycle = 0;
    logic [7:0] lastDoneData = 8'h00;
    int         doneCycles [0:63];
    logic [1:0] expKind [0:DEPTH-1];
    logic [7:0] expData [0:DEPTH-1];
    logic [7:0] modelData = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk      (clk),
        .i_reset    (rstN),
        .i_rx       (rxDrv),
        .i_enable   (enDrv),
        .o_data_out (dataOut),
        .o_done     (done),
        .o_frame_err(frameErr)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            if (failures <= 30)
                $display("[TB] FAIL %s actual=0x%0h required=0x%0h edge=%0d", name, actual, expected, edgeCnt);
        end
    endtask

    // Model: kind 1 = done expected this cycle, kind 2 = frame_err expected; reset clears the held byte.
    task automatic checkOutput(input bit rstAtEdge);
        int kind;
        kind = 0;
        if (rstAtEdge) begin
            modelData = 8'h00;
        end else if (edgeCnt < DEPTH) begin
            kind = int'(expKind[edgeCnt]);
            if (kind == 1) modelData = expData[edgeCnt];
        end
        compare("done", int'(done), (kind == 1) ? 1 : 0);
        compare("frame_err", int'(frameErr), (kind == 2) ? 1 : 0);
        compare("data_out", int'(dataOut), int'(modelData));
        if (done) begin
            if (doneCount < 64) doneCycles[doneCount] = edgeCnt;
            doneCount++;
            lastDoneCycle = edgeCnt;
            lastDoneData  = dataOut;
        end
        if (frameErr) ferrCount++;
    endtask

    task automatic tick();
        bit rstAt;
        @(posedge clk);
        edgeCnt++;
        rstAt = !rstN;
        #1;
        checkOutput(rstAt);
    endtask

    task automatic applyStimulus(input logic rxV);
        rxDrv = rxV;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input bit expectEvent,
                             input int dropAt, input bit spike, output int kOut);
        int   e;
        logic bitV;
        logic v;
        kOut = edgeCnt + 1;
        e    = kOut + 2 + HALF + 9 * CPB;
        if (expectEvent && e < DEPTH) begin
            expKind[e] = stopBit ? 2'd1 : 2'd2;
            expData[e] = b;
        end
        for (int pos = 0; pos < 10; pos++) begin
            if (pos == 0) bitV = 1'b0;
            else if (pos == 9) bitV = stopBit;
            else bitV = b[pos-1];
            if (dropAt >= 0 && pos == dropAt + 1) enDrv = 1'b0;
            for (int j = 0; j < CPB; j++) begin
                v = (spike && j == HALF) ? ~bitV : bitV;
                applyStimulus(v);
            end
        end
    endtask

    initial begin
        int k;
        int d0;
        int f0;
        for (int i = 0; i < DEPTH; i++) begin
            expKind[i] = 2'd0;
            expData[i] = 8'h00;
        end
        rstN  = 1'b0;
        rxDrv = 1'b1;
        enDrv = 1'b1;
        repeat (3) tick();
        compare("reset_data", int'(dataOut), 0);
        compare("reset_done", int'(done), 0);
        compare("reset_ferr", int'(frameErr), 0);
        rstN = 1'b1;
        idle(5);

        sendFrame(8'hA5, 1'b1, 1'b1, -1, 1'b0, k);
        idle(4);
        compare("a5_count", doneCount, 1);
        compare("a5_latency", lastDoneCycle - k, 154);
        compare("a5_data", int'(lastDoneData), 8'hA5);

        d0 = doneCount;
        sendFrame(8'h00, 1'b1, 1'b1, -1, 1'b0, k);
        sendFrame(8'hFF, 1'b1, 1'b1, -1, 1'b0, k);
        sendFrame(8'h3C, 1'b1, 1'b1, -1, 1'b0, k);
        idle(4);
        compare("b2b_count", doneCount - d0, 3);
        compare("b2b_gap1", doneCycles[d0+1] - doneCycles[d0], 160);
        compare("b2b_gap2", doneCycles[d0+2] - doneCycles[d0+1], 160);
        compare("b2b_last", int'(lastDoneData), 8'h3C);

        d0 = doneCount;
        sendFrame(8'h5A, 1'b0, 1'b1, -1, 1'b0, k);
        idle(30);
        compare("ferr_count", ferrCount, 1);
        compare("ferr_nodone", doneCount - d0, 0);
        compare("ferr_hold", int'(dataOut), 8'h3C);

        d0 = doneCount;
        f0 = ferrCount;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0);
        idle(20);
        compare("glitch_done", doneCount - d0, 0);
        compare("glitch_ferr", ferrCount - f0, 0);
        sendFrame(8'h81, 1'b1, 1'b1, -1, 1'b0, k);
        idle(4);
        compare("after_glitch", int'(lastDoneData), 8'h81);

        d0 = doneCount;
        sendFrame(8'h77, 1'b1, 1'b0, 3, 1'b0, k);
        idle(5);
        enDrv = 1'b1;
        idle(3);
        compare("abort_nodone", doneCount - d0, 0);
        sendFrame(8'h12, 1'b1, 1'b1, -1, 1'b0, k);
        idle(4);
        compare("enable_count", doneCount - d0, 1);
        compare("enable_data", int'(lastDoneData), 8'h12);

        for (int i = 0; i < CPB; i++) applyStimulus(1'b0);
        for (int i = 0; i < HALF; i++) applyStimulus(1'b1);
        rstN = 1'b0;
        applyStimulus(1'b1);
        compare("midreset_data", int'(dataOut), 0);
        compare("midreset_done", int'(done), 0);
        rstN = 1'b1;
        idle(20);
        sendFrame(8'hC3, 1'b1, 1'b1, -1, 1'b0, k);
        idle(4);
        compare("fresh_c3", int'(lastDoneData), 8'hC3);

`ifdef UART_RX_MAJORITY_EN
        sendFrame(8'hC3, 1'b1, 1'b1, -1, 1'b1, k);
        idle(4);
        compare("spike_c3_latency", lastDoneCycle - k, 154);
        compare("spike_c3", int'(lastDoneData), 8'hC3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
